// File: rtl/cpu_bus_interconnect_if.sv
// Bus bundle between the CPU native memory port, the interconnect and its slave ports.
// "slave" is the interconnect's view; "master" is the CPU/peripheral environment's view.
interface cpu_bus_interconnect_if #(
    parameter int NUM_SLAVES = 4
);
    logic                     m_valid;
    logic [31:0]              m_addr;
    logic [31:0]              m_wdata;
    logic [3:0]               m_wstrb;
    logic                     m_ready;
    logic [31:0]              m_rdata;
    logic [NUM_SLAVES-1:0]    s_valid;
    logic [31:0]              s_addr;
    logic [31:0]              s_wdata;
    logic [3:0]               s_wstrb;
    logic [NUM_SLAVES-1:0]    s_ready;
    logic [NUM_SLAVES*32-1:0] s_rdata;

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/cpu_bus_interconnect.sv
// Address-decoding interconnect for the picorv32 native port: routes to NUM_SLAVES windows,
// times out stalled slaves and answers unmapped/timed-out accesses with an error word.
module cpu_bus_interconnect #(
    parameter int                      NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE    = {32'h8000_2000, 32'h8000_1000, 32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK    = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFE_0000},
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    cpu_bus_interconnect_if.slave  bus,
    input  logic                   err_clear,
    output logic                   err_irq,
    output logic                   err_flag,
    output logic [31:0]            err_addr,
    output logic [15:0]            err_count
);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP, GUARD} state_t;

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
    logic [31:0]           s_addr_q, s_addr_d;
    logic [31:0]           s_wdata_q, s_wdata_d;
    logic [3:0]            s_wstrb_q, s_wstrb_d;
    logic [31:0]           m_rdata_q, m_rdata_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_resp_q, err_resp_d;
    logic                  err_flag_q, err_flag_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [15:0]           err_count_q, err_count_d;

    logic [NUM_SLAVES-1:0] match;
    logic                  hit;
    logic [SW-1:0]         hit_idx;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  timeout_hit;
    logic                  err_event;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
        assign match[gi] = (bus.m_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32];
    end

    // Scan downward so the lowest matching window ends up selected.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign sel_ready   = bus.s_ready[sel_q];
    assign sel_rdata   = bus.s_rdata[32*sel_q +: 32];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        s_valid_d  = s_valid_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        m_rdata_d  = m_rdata_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        err_resp_d = err_resp_q;
        err_event  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m_valid) begin
                    s_addr_d   = bus.m_addr;
                    s_wdata_d  = bus.m_wdata;
                    s_wstrb_d  = bus.m_wstrb;
                    err_resp_d = 1'b0;
                    if (hit) begin
                        s_valid_d = NUM_SLAVES'(1) << hit_idx;
                        sel_d     = hit_idx;
                        cnt_d     = '0;
                        state_d   = ACTIVE;
                    end else begin
                        m_rdata_d  = ERR_RDATA;
                        err_resp_d = 1'b1;
                        err_event  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ACTIVE: begin
                // A ready arriving on the last allowed cycle still beats the timeout.
                if (sel_ready) begin
                    m_rdata_d  = sel_rdata;
                    s_valid_d  = '0;
                    err_resp_d = 1'b0;
                    state_d    = RESP;
                end else if (timeout_hit) begin
                    m_rdata_d  = ERR_RDATA;
                    s_valid_d  = '0;
                    err_resp_d = 1'b1;
                    err_event  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                err_resp_d = 1'b0;
                state_d    = GUARD;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh error takes priority over err_clear, so the cleared count restarts at one.
    always_comb begin
        err_flag_d  = err_flag_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (err_event) begin
            err_flag_d  = 1'b1;
            err_addr_d  = (state_q == IDLE) ? bus.m_addr : s_addr_q;
            if (err_clear)
                err_count_d = 16'd1;
            else if (err_count_q != 16'hFFFF)
                err_count_d = err_count_q + 16'd1;
        end else if (err_clear) begin
            err_flag_d  = 1'b0;
            err_count_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            s_valid_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            m_rdata_q   <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            err_resp_q  <= 1'b0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_valid_q   <= s_valid_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            m_rdata_q   <= m_rdata_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            err_resp_q  <= err_resp_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.m_ready = (state_q == RESP);
    assign bus.m_rdata = m_rdata_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wstrb = s_wstrb_q;
    assign err_irq     = (state_q == RESP) && err_resp_q;
    assign err_flag    = err_flag_q;
    assign err_addr    = err_addr_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_cpu_bus_interconnect.sv
// Directed bench for cpu_bus_interconnect: slave models with programmable ready latency,
// hand-computed expectations for decode, latency, timeout, error status and reset abort.
module tb_cpu_bus_interconnect;
    logic        clk;
    logic        resetn;
    logic        err_clear;
    logic        err_irq;
    logic        err_flag;
    logic [31:0] err_addr;
    logic [15:0] err_count;

    cpu_bus_interconnect_if #(.NUM_SLAVES(4)) bus_if ();

    cpu_bus_interconnect dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus_if),
        .err_clear (err_clear),
        .err_irq   (err_irq),
        .err_flag  (err_flag),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave model: ready rises on the (lat+1)-th cycle of s_valid; lat < 0 means never.
    int          lat  [4];
    int          vcnt [4];
    logic [31:0] rd_tbl [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus_if.s_valid[i]) begin
                bus_if.s_ready[i] = (lat[i] >= 0) && (vcnt[i] == lat[i]);
                vcnt[i] = vcnt[i] + 1;
            end else begin
                bus_if.s_ready[i] = 1'b0;
                vcnt[i] = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Per-transaction observations
    int          sv_cnt [4];
    logic [3:0]  snap_sv;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_wstrb;
    logic [31:0] t_rdata;
    int          t_lat;
    logic        t_irq;

    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic clr);
        logic done;
        done = 1'b0;
        t_lat = 0;
        t_irq = 1'b0;
        t_rdata = '0;
        snap_sv = '0;
        for (int i = 0; i < 4; i++) sv_cnt[i] = 0;
        bus_if.m_addr  = addr;
        bus_if.m_wdata = wdata;
        bus_if.m_wstrb = wstrb;
        bus_if.m_valid = 1'b1;
        err_clear      = clr;
        while (!done && t_lat < 400) begin
            @(negedge clk);
            t_lat++;
            err_clear = 1'b0;
            for (int i = 0; i < 4; i++)
                if (bus_if.s_valid[i]) sv_cnt[i]++;
            if (|bus_if.s_valid) begin
                snap_sv    = bus_if.s_valid;
                snap_addr  = bus_if.s_addr;
                snap_wdata = bus_if.s_wdata;
                snap_wstrb = bus_if.s_wstrb;
            end
            if (bus_if.m_ready) begin
                done    = 1'b1;
                t_rdata = bus_if.m_rdata;
                t_irq   = err_irq;
            end
        end
        bus_if.m_valid = 1'b0;
        check("response_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("ready_one_cycle", {30'd0, bus_if.m_ready, err_irq}, 32'd0);
        @(negedge clk);
        $display("txn addr=%h wdata=%h wstrb=%b rdata=%h lat=%0d irq=%0b err_count=%0d",
                 addr, wdata, wstrb, t_rdata, t_lat, t_irq, err_count);
    endtask

    initial begin
        lat[0] = 2; lat[1] = -1; lat[2] = 0; lat[3] = -1;
        rd_tbl[0] = 32'h1234_5678;
        rd_tbl[1] = 32'h0BAD_F00D;
        rd_tbl[2] = 32'hCAFE_0002;
        rd_tbl[3] = 32'h3333_3333;
        for (int i = 0; i < 4; i++) begin
            vcnt[i] = 0;
            bus_if.s_rdata[32*i +: 32] = rd_tbl[i];
        end
        bus_if.m_valid = 1'b0;
        bus_if.m_addr  = '0;
        bus_if.m_wdata = '0;
        bus_if.m_wstrb = '0;
        err_clear      = 1'b0;
        resetn         = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_m_ready",   {31'd0, bus_if.m_ready}, 32'd0);
        check("rst_s_valid",   {28'd0, bus_if.s_valid}, 32'd0);
        check("rst_m_rdata",   bus_if.m_rdata, 32'd0);
        check("rst_s_addr",    bus_if.s_addr, 32'd0);
        check("rst_err_irq",   {31'd0, err_irq}, 32'd0);
        check("rst_err_flag",  {31'd0, err_flag}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        check("rst_err_addr",  err_addr, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Read slave0, ready after 2 wait cycles
        do_txn(32'h0001_0004, 32'h0, 4'b0000, 1'b0);
        check("rd0_rdata",   t_rdata, 32'h1234_5678);
        check("rd0_latency", t_lat, 32'd4);
        check("rd0_sv0",     sv_cnt[0], 32'd3);
        check("rd0_sv_mask", {28'd0, snap_sv}, 32'h1);
        check("rd0_irq",     {31'd0, t_irq}, 32'd0);
        check("rd0_errcnt",  {16'd0, err_count}, 32'd0);

        // Write to slave2, immediate ready
        do_txn(32'h8000_1010, 32'hA5A5_0000, 4'b1100, 1'b0);
        check("wr2_sv_mask", {28'd0, snap_sv}, 32'h4);
        check("wr2_s_addr",  snap_addr, 32'h8000_1010);
        check("wr2_s_wdata", snap_wdata, 32'hA5A5_0000);
        check("wr2_s_wstrb", {28'd0, snap_wstrb}, 32'hC);
        check("wr2_latency", t_lat, 32'd2);
        check("wr2_rdata",   t_rdata, 32'hCAFE_0002);

        // Unmapped read
        do_txn(32'h4000_0000, 32'h0, 4'b0000, 1'b0);
        check("unm_latency", t_lat, 32'd1);
        check("unm_rdata",   t_rdata, 32'hDEAD_BEEF);
        check("unm_irq",     {31'd0, t_irq}, 32'd1);
        check("unm_erraddr", err_addr, 32'h4000_0000);
        check("unm_errcnt",  {16'd0, err_count}, 32'd1);
        check("unm_errflag", {31'd0, err_flag}, 32'd1);
        check("unm_no_sval", sv_cnt[0] + sv_cnt[1] + sv_cnt[2] + sv_cnt[3], 32'd0);

        // Slave1 never ready -> timeout
        do_txn(32'h8000_0010, 32'h0, 4'b0000, 1'b0);
        check("to_sv1_cycles", sv_cnt[1], 32'd255);
        check("to_latency",    t_lat, 32'd256);
        check("to_rdata",      t_rdata, 32'hDEAD_BEEF);
        check("to_irq",        {31'd0, t_irq}, 32'd1);
        check("to_errcnt",     {16'd0, err_count}, 32'd2);
        check("to_erraddr",    err_addr, 32'h8000_0010);

        // Ready on the final timeout cycle wins
        lat[1] = 254;
        do_txn(32'h8000_0020, 32'h0, 4'b0000, 1'b0);
        check("last_sv1_cycles", sv_cnt[1], 32'd255);
        check("last_rdata",      t_rdata, 32'h0BAD_F00D);
        check("last_irq",        {31'd0, t_irq}, 32'd0);
        check("last_errcnt",     {16'd0, err_count}, 32'd2);

        // err_clear alone
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("clr_errcnt",  {16'd0, err_count}, 32'd0);
        check("clr_errflag", {31'd0, err_flag}, 32'd0);

        // err_clear coincident with an error
        do_txn(32'h4000_0100, 32'h0, 4'b0000, 1'b0);
        check("pre_co_errcnt", {16'd0, err_count}, 32'd1);
        do_txn(32'h5000_0000, 32'h0, 4'b0000, 1'b1);
        check("co_errcnt",  {16'd0, err_count}, 32'd1);
        check("co_errflag", {31'd0, err_flag}, 32'd1);
        check("co_erraddr", err_addr, 32'h5000_0000);

        // Saturation at 16'hFFFF
        force dut.err_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.err_count_q;
        @(negedge clk);
        check("sat_preload", {16'd0, err_count}, 32'h0000_FFFF);
        do_txn(32'h6000_0000, 32'h0, 4'b0000, 1'b0);
        check("sat_errcnt", {16'd0, err_count}, 32'h0000_FFFF);
        check("sat_irq",    {31'd0, t_irq}, 32'd1);

        // Reset while ACTIVE on slave3
        bus_if.m_addr  = 32'h8000_2004;
        bus_if.m_wstrb = 4'b0000;
        bus_if.m_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("ract_sv_mask", {28'd0, bus_if.s_valid}, 32'h8);
        resetn = 1'b0;
        bus_if.m_valid = 1'b0;
        @(negedge clk);
        check("ract_s_valid", {28'd0, bus_if.s_valid}, 32'd0);
        check("ract_m_ready", {31'd0, bus_if.m_ready}, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("ract_no_resp",  {30'd0, bus_if.m_ready, err_irq}, 32'd0);
        check("ract_errcnt",   {16'd0, err_count}, 32'd0);
        check("ract_errflag",  {31'd0, err_flag}, 32'd0);

        lat[0] = 0;
        do_txn(32'h0000_0040, 32'h0, 4'b0000, 1'b0);
        check("post_rdata",   t_rdata, 32'h1234_5678);
        check("post_latency", t_lat, 32'd2);
        check("post_irq",     {31'd0, t_irq}, 32'd0);
        check("post_errcnt",  {16'd0, err_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
